// File: rtl/trace_replay_pkg.sv
// Shared types for the trace replay engine: opcode and FSM state encodings.
package trace_replay_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 4'd0,
    OP_SEND   = 4'd1,
    OP_RECV   = 4'd2,
    OP_DONE   = 4'd3,
    OP_FINISH = 4'd4,
    OP_WAIT   = 4'd5,
    OP_SETCTR = 4'd6,
    OP_CHKCTR = 4'd7
  } op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/trace_replay_ctr.sv
// Cycle counter for the replay engine: load overrides a saturating decrement.
module trace_replay_ctr #(
  parameter int unsigned ctr_width_p = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_dec,
  input  logic                   i_load,
  input  logic [ctr_width_p-1:0] i_load_val,
  output logic                   o_zero
);

  logic [ctr_width_p-1:0] r_cnt;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ctr_width_p'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/trace_replay_node.sv
// Trace replay engine: walks a combinational trace ROM, drives payloads to the
// block under test, checks its responses, and flags done/error.
// Optional build macro TRACE_REPLAY_HALT_ON_ERROR_EN: any error event also
// stops replay (enters DONE) so no further ROM words are fetched.
// FINISH behaves exactly like DONE here; ending the simulation is left to the
// surrounding bench.
module trace_replay_node
  import trace_replay_pkg::*;
#(
  parameter int unsigned ring_width_p     = 98,
  parameter int unsigned rom_addr_width_p = 15,
  parameter int unsigned ctr_width_p      = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          en_i,
  input  logic                          v_i,
  input  logic [ring_width_p-1:0]       data_i,
  output logic                          ready_o,
  output logic                          v_o,
  output logic [ring_width_p-1:0]       data_o,
  input  logic                          yumi_i,
  output logic [rom_addr_width_p-1:0]   rom_addr_o,
  input  logic [ring_width_p+OP_W-1:0]  rom_data_i,
  output logic                          done_o,
  output logic                          error_o
);

  state_e                      r_state;
  state_e                      w_next_state;
  logic [rom_addr_width_p-1:0] r_addr;
  logic                        r_error;

  op_e                         w_op;
  logic [ring_width_p-1:0]     w_payload;
  logic                        w_active;
  logic                        w_advance;
  logic                        w_err_set;
  logic                        w_load;
  logic                        w_ctr_zero;
  logic                        w_v;
  logic                        w_ready;

  assign w_op      = op_e'(rom_data_i[ring_width_p +: OP_W]);
  assign w_payload = rom_data_i[ring_width_p-1:0];
  assign w_active  = (r_state == ST_RUN) && en_i;

  trace_replay_ctr #(
    .ctr_width_p(ctr_width_p)
  ) u_ctr (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_dec      (w_active),
    .i_load     (w_load),
    .i_load_val (w_payload[ctr_width_p-1:0]),
    .o_zero     (w_ctr_zero)
  );

  // State, trace address and sticky error register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_RUN;
      r_addr  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_advance) begin
        r_addr <= r_addr + rom_addr_width_p'(1);
      end
      if (w_err_set) begin
        r_error <= 1'b1;
      end
    end
  end

  // Opcode decode: handshakes, advance, error events and next state.
  always_comb begin
    w_next_state = r_state;
    w_advance    = 1'b0;
    w_err_set    = 1'b0;
    w_load       = 1'b0;
    w_v          = 1'b0;
    w_ready      = 1'b0;
    if (w_active) begin
      case (w_op)
        OP_NOP: w_advance = 1'b1;
        OP_SEND: begin
          w_v       = 1'b1;
          w_advance = yumi_i;
        end
        OP_RECV: begin
          w_ready = 1'b1;
          if (v_i) begin
            w_advance = 1'b1;
            w_err_set = (data_i != w_payload);
          end
        end
        OP_DONE, OP_FINISH: w_next_state = ST_DONE;
        OP_WAIT: w_advance = w_ctr_zero;
        OP_SETCTR: begin
          w_load    = 1'b1;
          w_advance = 1'b1;
        end
        OP_CHKCTR: begin
          w_advance = 1'b1;
          w_err_set = !w_ctr_zero;
        end
        default: begin
          w_advance = 1'b1;
          w_err_set = 1'b1;
        end
      endcase
`ifdef TRACE_REPLAY_HALT_ON_ERROR_EN
      if (w_err_set) begin
        w_next_state = ST_DONE;
      end
`endif
    end
  end

  assign v_o        = w_v;
  assign ready_o    = w_ready;
  assign data_o     = w_payload;
  assign rom_addr_o = r_addr;
  assign done_o     = (r_state == ST_DONE);
  assign error_o    = r_error;

endmodule

// File: tb/tb_trace_replay_node.sv
// Bench for trace_replay_node (ring 8 bits, 16-word ROM): directed trace
// scenarios with literal checks, then random traces against an interpreter
// model of the trace instruction set.
module tb_trace_replay_node;

  localparam int unsigned RW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          reset_i;
  logic          en_i;
  logic          v_i;
  logic [RW-1:0] data_i;
  logic          ready_o;
  logic          v_o;
  logic [RW-1:0] data_o;
  logic          yumi_i;
  logic [AW-1:0] rom_addr_o;
  logic [RW+3:0] rom_data_i;
  logic          done_o;
  logic          error_o;

  logic [11:0] rom [16];

  int n_tests = 0;
  int n_fail  = 0;

  trace_replay_node #(
    .ring_width_p     (RW),
    .rom_addr_width_p (AW),
    .ctr_width_p      (CW)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  assign rom_data_i = rom[rom_addr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Interpreter model: program counter, counter, done and error flags.
  logic          m_valid = 1'b0;
  logic [3:0]    m_pc;
  logic [CW-1:0] m_ctr;
  logic          m_done;
  logic          m_err;
  logic [3:0]    m_op;
  logic [7:0]    m_pay;
  logic [CW-1:0] m_nxt;
  logic          m_adv;
  logic          m_ev;

  always @(posedge clk) begin
    if (reset_i) begin
      m_pc = 0; m_ctr = 0; m_done = 0; m_err = 0; m_valid = 1;
    end else if (m_valid && en_i && !m_done) begin
      m_op  = rom[m_pc][11:8];
      m_pay = rom[m_pc][7:0];
      m_adv = 0;
      m_ev  = 0;
      m_nxt = (m_ctr == 0) ? 0 : m_ctr - 1;
      case (m_op)
        4'd0: m_adv = 1;
        4'd1: m_adv = yumi_i;
        4'd2: if (v_i) begin m_adv = 1; m_ev = (data_i != m_pay); end
        4'd3, 4'd4: m_done = 1;
        4'd5: m_adv = (m_ctr == 0);
        4'd6: begin m_nxt = m_pay; m_adv = 1; end
        4'd7: begin m_adv = 1; m_ev = (m_ctr != 0); end
        default: begin m_adv = 1; m_ev = 1; end
      endcase
      m_ctr = m_nxt;
      if (m_adv) m_pc = m_pc + 4'd1;
      if (m_ev) m_err = 1;
`ifdef TRACE_REPLAY_HALT_ON_ERROR_EN
      if (m_ev) m_done = 1;
`endif
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid && !reset_i) begin
      logic [3:0] op;
      logic       act;
      op  = rom[m_pc][11:8];
      act = en_i && !m_done;
      chk("rom_addr_o", 32'(rom_addr_o), 32'(m_pc));
      chk("done_o",     32'(done_o),     32'(m_done));
      chk("error_o",    32'(error_o),    32'(m_err));
      chk("v_o",        32'(v_o),        32'(act && op == 4'd1));
      chk("ready_o",    32'(ready_o),    32'(act && op == 4'd2));
      chk("data_o",     32'(data_o),     32'(rom[m_pc][7:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [11:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  task automatic do_reset();
    reset_i = 1; en_i = 1; yumi_i = 0; v_i = 0; data_i = 0;
    tick();
    tick();
    reset_i = 0;
  endtask

  initial begin
    int cnt;
    reset_i = 1; en_i = 0; yumi_i = 0; v_i = 0; data_i = 0;
    fill_rom(12'h300);

    // SEND with yumi three cycles after v_o rises
    rom[0] = 12'h1A5; rom[1] = 12'h300;
    do_reset();
    @(negedge clk);
    chk("reset_addr", 32'(rom_addr_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_err", 32'(error_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      yumi_i = (i == 3);
      @(negedge clk);
      chk("send_v", 32'(v_o), 32'd1);
      chk("send_data", 32'(data_o), 32'hA5);
      tick();
    end
    yumi_i = 0;
    @(negedge clk);
    chk("send_addr", 32'(rom_addr_o), 32'd1);
    tick();
    @(negedge clk);
    chk("send_done", 32'(done_o), 32'd1);
    chk("send_v_done", 32'(v_o), 32'd0);

    // RECV with matching data after two idle cycles
    rom[0] = 12'h23C;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v_i = (i == 2); data_i = 8'h3C;
      @(negedge clk);
      chk("recv_ready", 32'(ready_o), 32'd1);
      tick();
    end
    v_i = 0;
    tick();
    @(negedge clk);
    chk("recv_ok_err", 32'(error_o), 32'd0);
    chk("recv_ok_done", 32'(done_o), 32'd1);

    // RECV mismatch
    do_reset();
    v_i = 1; data_i = 8'h3D;
    tick();
    v_i = 0;
    @(negedge clk);
    chk("recv_bad_err", 32'(error_o), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("recv_bad_done", 32'(done_o), 32'd1);
    chk("recv_bad_addr", 32'(rom_addr_o), 32'd1);
    chk("recv_bad_sticky", 32'(error_o), 32'd1);

    // SETCTR 5 / WAIT / CHKCTR / DONE
    rom[0] = 12'h605; rom[1] = 12'h500; rom[2] = 12'h700; rom[3] = 12'h300;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rom_addr_o == 4'd1) cnt++;
      tick();
    end
    chk("wait_cycles", 32'(cnt), 32'd6);
    chk("wait_err", 32'(error_o), 32'd0);
    chk("wait_done", 32'(done_o), 32'd1);

    // Same trace with WAIT replaced by NOP: counter still nonzero at CHKCTR
    rom[1] = 12'h000;
    do_reset();
    repeat (6) tick();
    @(negedge clk);
    chk("chkctr_err", 32'(error_o), 32'd1);

    // en_i low mid-SEND freezes everything, yumi ignored meanwhile
    fill_rom(12'h300);
    rom[0] = 12'h1A5;
    do_reset();
    @(negedge clk);
    chk("en_v_before", 32'(v_o), 32'd1);
    tick();
    en_i = 0; yumi_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_frozen_v", 32'(v_o), 32'd0);
      chk("en_frozen_addr", 32'(rom_addr_o), 32'd0);
      tick();
    end
    en_i = 1;
    @(negedge clk);
    chk("en_resume_v", 32'(v_o), 32'd1);
    tick();
    yumi_i = 0;
    @(negedge clk);
    chk("en_resume_addr", 32'(rom_addr_o), 32'd1);

    // Reset pulse clears sticky error and restarts the trace
    rom[0] = 12'h23C;
    do_reset();
    v_i = 1; data_i = 8'h00;
    tick();
    reset_i = 1;
    tick();
    reset_i = 0; v_i = 0;
    @(negedge clk);
    chk("rst_addr", 32'(rom_addr_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(error_o), 32'd0);

    // Illegal opcode then DONE
    rom[0] = 12'hF00; rom[1] = 12'h300;
    do_reset();
    tick();
    @(negedge clk);
    chk("illegal_err", 32'(error_o), 32'd1);
    tick();
    @(negedge clk);
    chk("illegal_done", 32'(done_o), 32'd1);

    // 16 NOPs: address wraps 15 -> 0
    fill_rom(12'h000);
    do_reset();
    repeat (15) tick();
    @(negedge clk);
    chk("wrap_15", 32'(rom_addr_o), 32'd15);
    tick();
    @(negedge clk);
    chk("wrap_0", 32'(rom_addr_o), 32'd0);
    chk("wrap_err", 32'(error_o), 32'd0);

    // Random traces and handshake timing, checked by the model every cycle
    for (int run = 0; run < 40; run++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] op;
        logic [7:0] pay;
        op  = 4'($urandom_range(0, 15));
        if ((op == 4'd3 || op == 4'd4) && ($urandom % 3 != 0)) op = 4'd0;
        pay = 8'($urandom);
        if (op == 4'd6) pay = 8'($urandom_range(0, 7));
        rom[i] = {op, pay};
      end
      do_reset();
      for (int c = 0; c < 60; c++) begin
        en_i   = ($urandom % 6) != 0;
        yumi_i = ($urandom % 3) == 0;
        v_i    = ($urandom % 2) == 0;
        data_i = ($urandom % 2 == 0) ? rom[m_pc][7:0] : 8'($urandom);
        tick();
      end
    end

    en_i = 0; yumi_i = 0; v_i = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
